// File: rtl/uart_baud_timer_8051.sv
// rtl/uart_baud_timer_8051.sv - 8051 machine-cycle prescaler and Timer-1 auto-reload baud strobe
// Define UART_BAUD_SMOD_EN to build the SMOD half-rate divider; otherwise every overflow triggers.
module uart_baud_timer_8051 #(
  parameter int         UNIT_DIV      = 12,
  parameter logic [7:0] REG_ADDR_BCON = 8'h88,
  parameter logic [7:0] REG_ADDR_TH1  = 8'h8D,
  parameter logic [7:0] REG_ADDR_TL1  = 8'h8B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_wr_i,
  input  logic [7:0] adr_rd_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       class_8051_unit_pulse,
  output logic       timer_trigger
);

  localparam int            PW       = $clog2(UNIT_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_DIV - 1);
  localparam logic [PW-1:0] PRE_ARM  = PW'(UNIT_DIV - 2);

  logic [PW-1:0] prescaler;
  logic          tr;
  logic          smod;
  logic [7:0]    th1;
  logic [7:0]    tl1;
  logic          wr;
  logic          wr_bcon;
  logic          wr_th1;
  logic          wr_tl1;
  logic          run_start;
  logic          advance;
  logic          overflow;

  assign wr        = stb_i & we_i;
  assign wr_bcon   = wr & (adr_wr_i == REG_ADDR_BCON);
  assign wr_th1    = wr & (adr_wr_i == REG_ADDR_TH1);
  assign wr_tl1    = wr & (adr_wr_i == REG_ADDR_TL1);
  assign run_start = wr_bcon & ~tr & dat_i[0];
  assign advance   = tr & class_8051_unit_pulse;
  // A bus write to TL1 wins over the reload and swallows that overflow.
  assign overflow  = advance & (tl1 == 8'hFF) & ~wr_tl1;
  assign ack_o     = stb_i;

  // Pulse is armed one count early so it is high while the prescaler sits at its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler             <= '0;
      class_8051_unit_pulse <= 1'b0;
    end else begin
      prescaler             <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      class_8051_unit_pulse <= (prescaler == PRE_ARM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tr  <= 1'b0;
      th1 <= 8'h00;
      tl1 <= 8'h00;
    end else begin
      if (wr_bcon) tr <= dat_i[0];
      if (wr_th1) th1 <= dat_i;
      if (wr_tl1)
        tl1 <= dat_i;
      else if (run_start)
        tl1 <= th1;
      else if (advance)
        tl1 <= (tl1 == 8'hFF) ? th1 : tl1 + 8'd1;
    end
  end

`ifdef UART_BAUD_SMOD_EN
  logic half;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smod          <= 1'b0;
      half          <= 1'b0;
      timer_trigger <= 1'b0;
    end else begin
      if (wr_bcon) smod <= dat_i[1];
      timer_trigger <= overflow & (smod | half);
      if (wr_bcon | ~tr)
        half <= 1'b0;
      else if (overflow)
        half <= ~half;
    end
  end
`else
  assign smod = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer_trigger <= 1'b0;
    else
      timer_trigger <= overflow;
  end
`endif

  always_comb begin
    dat_o = 8'h00;
    if (adr_rd_i == REG_ADDR_BCON)
      dat_o = {6'b000000, smod, tr};
    else if (adr_rd_i == REG_ADDR_TH1)
      dat_o = th1;
    else if (adr_rd_i == REG_ADDR_TL1)
      dat_o = tl1;
  end

endmodule

// File: tb/tb_uart_baud_timer_8051.sv
// tb/tb_uart_baud_timer_8051.sv - self-checking bench for uart_baud_timer_8051
// Expectations adapt to whether UART_BAUD_SMOD_EN is defined.
module tb_uart_baud_timer_8051;

  localparam int         UD      = 12;
  localparam logic [7:0] A_BCON  = 8'h88;
  localparam logic [7:0] A_TH1   = 8'h8D;
  localparam logic [7:0] A_TL1   = 8'h8B;
  localparam logic [7:0] A_OTHER = 8'h42;
`ifdef UART_BAUD_SMOD_EN
  localparam bit SMOD_EN = 1'b1;
`else
  localparam bit SMOD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic [7:0] adr_wr_i = 8'h00;
  logic [7:0] adr_rd_i = 8'h00;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       class_8051_unit_pulse;
  logic       timer_trigger;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] addrs [4];

  // Reference model state, in spec terms: cycle number since reset release and register values
  int m_cycle;
  bit m_tr, m_smod, m_trig;
  int m_th1, m_tl1, m_ovf;

  int obs_cycle, obs_dat;
  bit obs_trig, obs_pulse;

  always #5 clk = ~clk;

  uart_baud_timer_8051 #(
    .UNIT_DIV(UD), .REG_ADDR_BCON(A_BCON), .REG_ADDR_TH1(A_TH1), .REG_ADDR_TL1(A_TL1)
  ) dut (
    .clk(clk), .reset(reset), .stb_i(stb_i), .we_i(we_i), .adr_wr_i(adr_wr_i),
    .adr_rd_i(adr_rd_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .class_8051_unit_pulse(class_8051_unit_pulse), .timer_trigger(timer_trigger)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, m_cycle);
  endtask

  function automatic int m_read(input logic [7:0] a);
    if (a == A_BCON) return (m_smod ? 2 : 0) + (m_tr ? 1 : 0);
    if (a == A_TH1) return m_th1;
    if (a == A_TL1) return m_tl1;
    return 0;
  endfunction

  function automatic void m_reset();
    m_cycle = 1; m_tr = 0; m_smod = 0; m_trig = 0;
    m_th1 = 0; m_tl1 = 0; m_ovf = 0;
  endfunction

  // One bus cycle: drive, sample mid-cycle against the model, then advance the model across the edge.
  task automatic step(input bit s, input bit w, input logic [7:0] aw, input logic [7:0] d,
                      input logic [7:0] ar);
    bit wr, pulse, ovf, trig_n;
    stb_i = s; we_i = w; adr_wr_i = aw; dat_i = d; adr_rd_i = ar;
    @(negedge clk);
    pulse = (m_cycle % UD == 0);
    check("unit_pulse", int'(class_8051_unit_pulse), int'(pulse));
    check("timer_trigger", int'(timer_trigger), int'(m_trig));
    check("dat_o", int'(dat_o), m_read(ar));
    check("ack_o", int'(ack_o), int'(s));
    obs_cycle = m_cycle; obs_dat = int'(dat_o);
    obs_trig = timer_trigger; obs_pulse = class_8051_unit_pulse;
    @(posedge clk);
    wr = s && w;
    ovf = m_tr && pulse && m_tl1 == 255 && !(wr && aw == A_TL1);
    trig_n = 0;
    if (ovf) begin
      m_ovf++;
      trig_n = !SMOD_EN || m_smod || (m_ovf % 2 == 0);
    end
    if ((wr && aw == A_BCON) || !m_tr) m_ovf = 0;
    if (wr && aw == A_TL1) m_tl1 = int'(d);
    else if (wr && aw == A_BCON && !m_tr && d[0]) m_tl1 = m_th1;
    else if (m_tr && pulse) m_tl1 = (m_tl1 == 255) ? m_th1 : m_tl1 + 1;
    if (wr && aw == A_BCON) begin
      m_tr = d[0];
      if (SMOD_EN) m_smod = d[1];
    end
    if (wr && aw == A_TH1) m_th1 = int'(d);
    m_trig = trig_n;
    m_cycle++;
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, a);
  endtask

  task automatic idle(input logic [7:0] ar);
    step(1'b0, 1'b0, 8'h00, 8'h00, ar);
  endtask

  task automatic do_reset();
    stb_i = 0; we_i = 0;
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check("rst_unit_pulse", int'(class_8051_unit_pulse), 0);
    check("rst_trigger", int'(timer_trigger), 0);
    adr_rd_i = A_TL1; #1 check("rst_tl1", int'(dat_o), 0);
    adr_rd_i = A_BCON; #1 check("rst_bcon", int'(dat_o), 0);
    adr_rd_i = A_TH1; #1 check("rst_th1", int'(dat_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic run_until_read(input logic [7:0] ar, input int val, input int budget,
                                input string name);
    int k;
    k = 0;
    do begin
      idle(ar);
      k++;
    end while (obs_dat != val && k < budget);
    check(name, obs_dat, val);
  endtask

  task automatic check_trigger_gaps(input int n_gaps, input int exp_gap, input string name);
    int prev, gaps, k;
    prev = -1; gaps = 0; k = 0;
    while (gaps < n_gaps && k < (n_gaps + 3) * exp_gap * 2) begin
      idle(A_TL1);
      k++;
      if (obs_trig) begin
        if (prev >= 0) begin
          check(name, obs_cycle - prev, exp_gap);
          gaps++;
        end
        prev = obs_cycle;
      end
    end
    check({name, "_count"}, gaps, n_gaps);
  endtask

  typedef struct {
    bit         s;
    bit         w;
    logic [7:0] aw;
    logic [7:0] d;
    logic [7:0] ar;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [12];

  initial begin
    int first, npulse, ntrig, w;

    addrs[0] = A_BCON; addrs[1] = A_TH1; addrs[2] = A_TL1; addrs[3] = A_OTHER;
    // Register-port vectors from a cleared, stopped timer; exp is the read before the write edge.
    vt[0]  = '{1, 1, A_TH1,  8'h5A, A_TH1,   8'h00};
    vt[1]  = '{1, 1, A_TL1,  8'h33, A_TH1,   8'h5A};
    vt[2]  = '{0, 1, A_TL1,  8'h99, A_TL1,   8'h33};
    vt[3]  = '{1, 0, A_TL1,  8'h99, A_TL1,   8'h33};
    vt[4]  = '{1, 1, A_BCON, 8'hFC, A_TL1,   8'h33};
    vt[5]  = '{0, 0, A_BCON, 8'h00, A_BCON,  8'h00};
    vt[6]  = '{1, 1, A_BCON, 8'h02, A_OTHER, 8'h00};
    vt[7]  = '{1, 0, A_BCON, 8'h00, A_BCON,  SMOD_EN ? 8'h02 : 8'h00};
    vt[8]  = '{1, 1, A_TH1,  8'hA5, A_BCON,  SMOD_EN ? 8'h02 : 8'h00};
    vt[9]  = '{0, 0, A_TH1,  8'h00, A_TH1,   8'hA5};
    vt[10] = '{1, 1, A_BCON, 8'h00, A_TL1,   8'h33};
    vt[11] = '{0, 0, A_BCON, 8'h00, A_BCON,  8'h00};

    m_reset();
    do_reset();

    // Reset release: pulses at 12, 24, 36 and nothing else moves
    first = -1; npulse = 0; ntrig = 0;
    for (int k = 0; k < 40; k++) begin
      idle(addrs[k % 4]);
      if (obs_pulse) begin
        if (first < 0) first = obs_cycle;
        npulse++;
      end
      if (obs_trig) ntrig++;
    end
    check("first_pulse_cycle", first, 12);
    check("pulse_count_40", npulse, 3);
    check("reset_no_trigger", ntrig, 0);

    for (int i = 0; i < 12; i++) begin
      step(vt[i].s, vt[i].w, vt[i].aw, vt[i].d, vt[i].ar);
      check($sformatf("vec%0d_dat", i), obs_dat, int'(vt[i].exp));
    end

    // TH1=FD, SMOD=1: 36 clk between triggers
    wr_reg(A_TH1, 8'hFD);
    wr_reg(A_BCON, 8'h03);
    idle(A_BCON);
    check("bcon_03_read", obs_dat, SMOD_EN ? 3 : 1);
    check_trigger_gaps(4, 36, "gap_fd_smod1");

    // SMOD=0: halved rate only when the divider is built
    wr_reg(A_BCON, 8'h00);
    wr_reg(A_BCON, 8'h01);
    idle(A_BCON);
    check("bcon_01_read", obs_dat, 1);
    check_trigger_gaps(4, SMOD_EN ? 72 : 36, "gap_fd_smod0");

    // Stop at TL1=0x80, hold, restart aligned to a unit pulse
    wr_reg(A_BCON, 8'h00);
    wr_reg(A_TH1, 8'h00);
    wr_reg(A_BCON, 8'h03);
    run_until_read(A_TL1, 8'h80, 128 * UD + 40, "tl1_reach_80");
    wr_reg(A_BCON, 8'h00);
    ntrig = 0;
    for (int k = 0; k < 400; k++) begin
      idle(A_TL1);
      if (obs_trig) ntrig++;
    end
    check("hold_tl1", obs_dat, 8'h80);
    check("hold_no_trigger", ntrig, 0);
    while (m_cycle % UD != 0) idle(A_TL1);
    step(1'b1, 1'b1, A_BCON, 8'h03, A_TL1);
    w = obs_cycle;
    idle(A_TL1);
    check("restart_tl1_reload", obs_dat, 0);
    ntrig = 0;
    while (!obs_trig && ntrig < 3200) begin
      idle(A_TL1);
      ntrig++;
    end
    check("restart_first_trigger", obs_cycle - w - 1, 256 * UD);

    // TH1=FF: trigger on every unit pulse
    wr_reg(A_BCON, 8'h00);
    wr_reg(A_TH1, 8'hFF);
    wr_reg(A_BCON, 8'h03);
    check_trigger_gaps(4, UD, "gap_ff");

    // TL1 write colliding with the FF->reload edge
    wr_reg(A_BCON, 8'h00);
    wr_reg(A_TH1, 8'hF0);
    wr_reg(A_BCON, 8'h03);
    run_until_read(A_TL1, 8'hFF, 20 * UD, "tl1_reach_ff");
    while (m_cycle % UD != 0) idle(A_TL1);
    step(1'b1, 1'b1, A_TL1, 8'hFE, A_TL1);
    w = obs_cycle;
    idle(A_TL1);
    check("collide_tl1", obs_dat, 8'hFE);
    check("collide_no_trigger", int'(obs_trig), 0);
    ntrig = 0;
    while (!obs_trig && ntrig < 4 * UD) begin
      idle(A_TL1);
      ntrig++;
    end
    check("collide_next_overflow", obs_cycle - w, 2 * UD + 1);

    // Randomised traffic against the model, with one asynchronous reset mid-run
    for (int i = 0; i < 1500; i++) begin
      bit s, wv;
      logic [7:0] aw, d, ar;
      s = ($urandom_range(0, 7) == 0);
      wv = s && ($urandom_range(0, 3) != 0);
      aw = addrs[$urandom_range(0, 3)];
      if (aw == A_TH1) d = 8'($urandom_range(8'hF0, 8'hFF));
      else if (aw == A_TL1) d = 8'($urandom_range(8'hE0, 8'hFF));
      else begin
        d = 8'($urandom);
        d[0] = ($urandom_range(0, 3) != 0);
      end
      ar = addrs[$urandom_range(0, 3)];
      if (i == 700) do_reset();
      step(s, wv, aw, d, ar);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
